// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction RAM address/enable, IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add the perf_fetch / perf_stall counters.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic        halt,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] instr_next, pc4_next;
  logic        valid_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // Gated by reset so the enable reads 0 while reset is held, yet 1 during the BOOT cycle.
  assign imem_en   = (state != S_HALT) && !reset;

  // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = ifid_instr;
    pc4_next   = ifid_pc4;
    valid_next = ifid_valid;
    case (state)
      S_BOOT: begin
        state_next = S_RUN;
        instr_next = NOP_WORD;
        pc4_next   = 32'd0;
        valid_next = 1'b0;
      end
      S_RUN: begin
        if (halt) begin
          state_next = S_HALT;
          instr_next = NOP_WORD;
          pc4_next   = 32'd0;
          valid_next = 1'b0;
        end else if (branch_taken) begin
          pc_next    = branch_target;
          instr_next = NOP_WORD;
          pc4_next   = 32'd0;
          valid_next = 1'b0;
        end else if (stall && flush) begin
          instr_next = NOP_WORD;
          pc4_next   = 32'd0;
          valid_next = 1'b0;
        end else if (stall) begin
          pc_next = pc;
        end else if (flush) begin
          pc_next    = pc_plus4;
          instr_next = NOP_WORD;
          pc4_next   = 32'd0;
          valid_next = 1'b0;
        end else begin
          pc_next    = pc_plus4;
          instr_next = imem_data;
          pc4_next   = pc_plus4;
          valid_next = 1'b1;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_BOOT;
      pc         <= PC_RESET;
      ifid_instr <= NOP_WORD;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_instr <= instr_next;
      ifid_pc4   <= pc4_next;
      ifid_valid <= valid_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch <= 32'd0;
      perf_stall <= 32'd0;
    end else if (state == S_RUN && !halt && !branch_taken) begin
      if (!stall && !flush) perf_fetch <= perf_fetch + 32'd1;
      if (stall)            perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: the driver queues the expected post-edge outputs,
// a monitor pops and compares them one time unit after each rising edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, flush, halt;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_data;
  logic        imem_en;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        en;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   step_id = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .flush         (flush),
    .halt          (halt),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch    (perf_fetch),
    .perf_stall    (perf_stall)
`endif
  );

  // Instruction RAM contents: three program words, a tagged pattern elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'hE3A0_1005;
      32'h0000_0004: rom = 32'hE281_1001;
      32'h0000_0008: rom = 32'hE081_2001;
      default:       rom = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check($sformatf("%s addr", tag),  imem_addr,        e.addr);
    check($sformatf("%s en", tag),    {31'd0, imem_en}, {31'd0, e.en});
    check($sformatf("%s instr", tag), ifid_instr,       e.instr);
    check($sformatf("%s pc4", tag),   ifid_pc4,         e.pc4);
    check($sformatf("%s valid", tag), {31'd0, ifid_valid}, {31'd0, e.valid});
  endtask

  // Drive one cycle's inputs, queue the outputs expected after the next edge, then advance.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic fl, input logic ht,
                      input logic [31:0] e_addr, input logic e_en,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    exp_t e;
    stall = st; branch_taken = br; branch_target = tgt; flush = fl; halt = ht;
    step_id++;
    e.id = step_id; e.addr = e_addr; e.en = e_en;
    e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares whatever the driver has queued, one time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_outputs($sformatf("step%0d", e.id), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t r;
    r.id = 0; r.addr = 32'h0; r.en = 1'b0; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0;

    reset = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; flush = 1'b0; halt = 1'b0;
    #12;
    check_outputs("reset", r);
`ifdef FETCH_PERF_CNT_EN
    check("reset perf_fetch", perf_fetch, 32'd0);
    check("reset perf_stall", perf_stall, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    //    st  br  target         fl  ht   addr           en  instr          pc4            v
    step(0, 0, 32'h0,          0, 1,  32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000, 0); // BOOT, halt ignored
    step(0, 0, 32'h0,          0, 0,  32'h0000_0004, 1, 32'hE3A0_1005, 32'h0000_0004, 1);
    step(0, 0, 32'h0,          0, 0,  32'h0000_0008, 1, 32'hE281_1001, 32'h0000_0008, 1);
    step(1, 0, 32'h0,          0, 0,  32'h0000_0008, 1, 32'hE281_1001, 32'h0000_0008, 1);
    step(1, 0, 32'h0,          0, 0,  32'h0000_0008, 1, 32'hE281_1001, 32'h0000_0008, 1);
    step(1, 0, 32'h0,          0, 0,  32'h0000_0008, 1, 32'hE281_1001, 32'h0000_0008, 1);
    step(0, 0, 32'h0,          0, 0,  32'h0000_000C, 1, 32'hE081_2001, 32'h0000_000C, 1);
    step(0, 0, 32'h0,          0, 0,  32'h0000_0010, 1, 32'hC0DE_000C, 32'h0000_0010, 1);
    step(1, 1, 32'h0000_0040,  0, 0,  32'h0000_0040, 1, 32'h0000_0000, 32'h0000_0000, 0); // branch beats stall
    step(0, 0, 32'h0,          0, 0,  32'h0000_0044, 1, 32'hC0DE_0040, 32'h0000_0044, 1);
    step(0, 1, 32'h0000_0020,  0, 0,  32'h0000_0020, 1, 32'h0000_0000, 32'h0000_0000, 0);
    step(0, 0, 32'h0,          1, 0,  32'h0000_0024, 1, 32'h0000_0000, 32'h0000_0000, 0); // flush alone
    step(0, 0, 32'h0,          0, 0,  32'h0000_0028, 1, 32'hC0DE_0024, 32'h0000_0028, 1);
    step(1, 0, 32'h0,          1, 0,  32'h0000_0028, 1, 32'h0000_0000, 32'h0000_0000, 0); // flush+stall
    step(0, 0, 32'h0,          0, 0,  32'h0000_002C, 1, 32'hC0DE_0028, 32'h0000_002C, 1);
    step(0, 1, 32'hFFFF_FFFC,  0, 0,  32'hFFFF_FFFC, 1, 32'h0000_0000, 32'h0000_0000, 0);
    step(0, 0, 32'h0,          0, 0,  32'h0000_0000, 1, 32'hC0DE_FFFC, 32'h0000_0000, 1); // PC+4 wraps
    step(0, 1, 32'h0000_0041,  0, 0,  32'h0000_0041, 1, 32'h0000_0000, 32'h0000_0000, 0); // unaligned target
    step(0, 0, 32'h0,          0, 0,  32'h0000_0045, 1, 32'hC0DE_0041, 32'h0000_0045, 1);
    step(1, 1, 32'h0000_0080,  1, 1,  32'h0000_0045, 0, 32'h0000_0000, 32'h0000_0000, 0); // halt wins
    step(0, 1, 32'h0000_0080,  0, 0,  32'h0000_0045, 0, 32'h0000_0000, 32'h0000_0000, 0);
    step(1, 0, 32'h0,          1, 1,  32'h0000_0045, 0, 32'h0000_0000, 32'h0000_0000, 0);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch, 32'd9);
    check("perf_stall", perf_stall, 32'd4);
`endif

    // Asynchronous reset from HALT, between edges.
    reset = 1'b1;
    #1;
    check_outputs("async_reset", r);
`ifdef FETCH_PERF_CNT_EN
    check("async_reset perf_fetch", perf_fetch, 32'd0);
    check("async_reset perf_stall", perf_stall, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    step(0, 0, 32'h0,          0, 0,  32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000, 0);
    step(0, 0, 32'h0,          0, 0,  32'h0000_0004, 1, 32'hE3A0_1005, 32'h0000_0004, 1);
    step(0, 0, 32'h0,          0, 0,  32'h0000_0008, 1, 32'hE281_1001, 32'h0000_0008, 1);

    @(posedge clk);
    #2;
    check("scoreboard drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
